// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: sequential instruction fetch from a combinational instruction
// memory into a single fetch/decode holding register with valid/ready
// handshake, branch/jump redirect, and a terminal DONE state once the PC
// reaches PROG_LEN.
//
// Parameters:
//   PROG_LEN  number of valid instruction words, 1..32 (default 15)
//   RESET_PC  PC loaded on reset (default 0)
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_addr[4:0]  instruction memory word address (= PC)
//   imem_rd         instruction memory read strobe
//   imem_rdata[31:0] instruction memory read data (same cycle)
//   redirect_valid  redirect request (highest priority)
//   redirect_pc[4:0] redirect target
//   out_valid       holding register contains an instruction
//   out_ready       decode accepts the held instruction this cycle
//   out_instr[31:0] held instruction word
//   out_pc[4:0]     address of the held instruction
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_count[15:0]  saturating count of transfers to decode
//   stall_count[15:0]  saturating count of cycles valid && !ready
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int PROG_LEN = 15,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [4:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [4:0]  out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  // PROG_LEN of 32 wraps to 0, matching the 5-bit PC after increment.
  localparam logic [4:0] END_PC   = 5'(PROG_LEN % 32);
  localparam logic [4:0] START_PC = 5'(RESET_PC);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  opc_q, opc_d;

  logic        load;
  logic        xfer;
  logic [4:0]  pc_inc;

  assign load   = (state_q == S_FETCH) && (!valid_q || out_ready) && !redirect_valid;
  assign xfer   = valid_q && out_ready;
  assign pc_inc = pc_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= START_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      opc_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    if (redirect_valid) begin
      // A coincident transfer is still consumed by decode; the register
      // is flushed either way. Stale instr/pc are left in place (valid=0).
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = S_FETCH;
    end else if (load) begin
      instr_d = imem_rdata;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_inc;
      if (pc_inc == END_PC) begin
        state_d = S_DONE;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  assign imem_addr = pc_q;
  // rst_n gating forces the strobe low while reset is held.
  assign imem_rd   = load && rst_n;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      if (xfer && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (valid_q && !out_ready && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = 5'd0;
  logic        out_ready = 1'b0;

  logic [31:0] mem [32];

  // instance a: PROG_LEN 15, RESET_PC 0; instance b: PROG_LEN 32, RESET_PC 3
  logic [4:0]  a_addr, b_addr, a_pc, b_pc;
  logic        a_rd, b_rd, a_valid, b_valid;
  logic [31:0] a_rdata, b_rdata, a_instr, b_instr;
  logic [15:0] a_fc, a_sc, b_fc, b_sc;

  assign a_rdata = mem[a_addr];
  assign b_rdata = mem[b_addr];

`ifndef FETCH_PERF_CNT_EN
  assign a_fc = 16'd0;
  assign a_sc = 16'd0;
  assign b_fc = 16'd0;
  assign b_sc = 16'd0;
`endif

  instr_fetch_unit #(.PROG_LEN(15), .RESET_PC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_addr(a_addr), .imem_rd(a_rd),
    .imem_rdata(a_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(a_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(a_fc), .stall_count(a_sc)
`endif
  );

  instr_fetch_unit #(.PROG_LEN(32), .RESET_PC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_addr(b_addr), .imem_rd(b_rd),
    .imem_rdata(b_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(b_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(b_fc), .stall_count(b_sc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one fetch stream per instance, tracked as integers.
  int  m_len   [2] = '{15, 32};
  int  m_rstpc [2] = '{0, 3};
  int  m_pc    [2];
  bit  m_fetch [2];
  bit  m_valid [2];
  int  m_instr [2];
  int  m_opc   [2];
  int  m_fc    [2];
  int  m_sc    [2];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pc[m] = m_rstpc[m]; m_fetch[m] = 1'b1; m_valid[m] = 1'b0;
      m_instr[m] = 0; m_opc[m] = 0; m_fc[m] = 0; m_sc[m] = 0;
    end
  endtask

  task automatic model_tick();
    bit tr;
    if (!rst_n) return;
    for (int m = 0; m < 2; m++) begin
      tr = m_valid[m] && out_ready;
      if (tr && m_fc[m] < 65535) m_fc[m]++;
      if (m_valid[m] && !out_ready && m_sc[m] < 65535) m_sc[m]++;
      if (redirect_valid) begin
        m_pc[m] = redirect_pc; m_valid[m] = 1'b0; m_fetch[m] = 1'b1;
      end else if (m_fetch[m] && (!m_valid[m] || out_ready)) begin
        m_instr[m] = mem[m_pc[m]]; m_opc[m] = m_pc[m]; m_valid[m] = 1'b1;
        m_pc[m] = (m_pc[m] + 1) % 32;
        if (m_pc[m] == m_len[m] % 32) m_fetch[m] = 1'b0;
      end else if (tr) begin
        m_valid[m] = 1'b0;
      end
    end
  endtask

  task automatic check_inst(input int m, input logic rd, input logic [4:0] addr,
                            input logic valid, input logic [4:0] opc,
                            input logic [31:0] instr, input logic [15:0] fc,
                            input logic [15:0] sc);
    logic rd_e;
    rd_e = rst_n && m_fetch[m] && (!m_valid[m] || out_ready) && !redirect_valid;
    chk($sformatf("m%0d imem_rd", m), 32'(rd), 32'(rd_e));
    chk($sformatf("m%0d imem_addr", m), 32'(addr), 32'(m_pc[m]));
    chk($sformatf("m%0d out_valid", m), 32'(valid), 32'(m_valid[m]));
    if (m_valid[m]) begin
      chk($sformatf("m%0d out_pc", m), 32'(opc), 32'(m_opc[m]));
      chk($sformatf("m%0d out_instr", m), instr, 32'(m_instr[m]));
    end
`ifdef FETCH_PERF_CNT_EN
    chk($sformatf("m%0d fetch_count", m), 32'(fc), 32'(m_fc[m]));
    chk($sformatf("m%0d stall_count", m), 32'(sc), 32'(m_sc[m]));
`endif
  endtask

  // Inputs are driven just after a falling edge; settle checks before the
  // next rising edge, tick advances both DUTs and the model.
  task automatic settle();
    #1;
    check_inst(0, a_rd, a_addr, a_valid, a_pc, a_instr, a_fc, a_sc);
    check_inst(1, b_rd, b_addr, b_valid, b_pc, b_instr, b_fc, b_sc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       ready;
    logic       rv;
    logic [4:0] rpc;
    logic       exp_rd;
    logic [4:0] exp_addr;
    logic       exp_valid;
    logic [4:0] exp_pc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // stall after first load, then redirect to 9 while out_pc = 3 is valid
    tbl[0] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd0,  1'b0, 5'd0};
    tbl[1] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd1,  1'b1, 5'd0};
    tbl[2] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd1,  1'b1, 5'd0};
    tbl[3] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd1,  1'b1, 5'd0};
    tbl[4] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd1,  1'b1, 5'd0};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd2,  1'b1, 5'd1};
    tbl[6] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd3,  1'b1, 5'd2};
    tbl[7] = '{1'b1, 1'b1, 5'd9, 1'b0, 5'd4,  1'b1, 5'd3};
    tbl[8] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd9,  1'b0, 5'd0};
    tbl[9] = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 5'd9};

    for (int i = 0; i < 32; i++) mem[i] = $urandom();
    model_reset();
    @(negedge clk);

    // reset state
    do_reset();

    // full run, PROG_LEN 15, ready held high
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 15; k++) begin
      settle();
      chk("run out_valid", 32'(a_valid), 32'd1);
      chk("run out_pc", 32'(a_pc), 32'(k));
      tick();
    end
    settle();
    chk("done imem_rd", 32'(a_rd), 32'd0);
    chk("done out_valid", 32'(a_valid), 32'd0);
    chk("done pc", 32'(a_addr), 32'd15);
    tick();
    step();

    // redirect to 2 while in DONE
    redirect_valid = 1'b1; redirect_pc = 5'd2;
    step();
    redirect_valid = 1'b0;
    step();
    for (int k = 2; k < 15; k++) begin
      settle();
      chk("resume out_pc", 32'(a_pc), 32'(k));
      chk("resume out_instr", a_instr, mem[k]);
      tick();
    end
    settle();
    chk("resume done rd", 32'(a_rd), 32'd0);
    tick();

    // table: stall then redirect to 9
    do_reset();
    for (int i = 0; i < 10; i++) begin
      out_ready = tbl[i].ready; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      settle();
      chk($sformatf("tbl%0d imem_rd", i), 32'(a_rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d imem_addr", i), 32'(a_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d out_valid", i), 32'(a_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d out_pc", i), 32'(a_pc), 32'(tbl[i].exp_pc));
        chk($sformatf("tbl%0d out_instr", i), a_instr, mem[tbl[i].exp_pc]);
      end
      tick();
    end
    redirect_valid = 1'b0;

    // PROG_LEN 32 wrap: redirect to 30
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd30;
    step();
    redirect_valid = 1'b0;
    step();
    settle();
    chk("wrap out_pc 30", 32'(b_pc), 32'd30);
    tick();
    settle();
    chk("wrap out_pc 31", 32'(b_pc), 32'd31);
    chk("wrap rd after 31", 32'(b_rd), 32'd0);
    chk("wrap pc", 32'(b_addr), 32'd0);
    tick();
    settle();
    chk("wrap out_valid", 32'(b_valid), 32'd0);
    chk("wrap done rd", 32'(b_rd), 32'd0);
    tick();

    // reset pulsed mid-stall
    redirect_valid = 1'b1; redirect_pc = 5'd5;
    step();
    redirect_valid = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst a out_valid", 32'(a_valid), 32'd0);
    chk("arst a out_instr", a_instr, 32'd0);
    chk("arst a out_pc", 32'(a_pc), 32'd0);
    chk("arst a imem_rd", 32'(a_rd), 32'd0);
    chk("arst b out_valid", 32'(b_valid), 32'd0);
    chk("arst b imem_addr", 32'(b_addr), 32'd3);
`ifdef FETCH_PERF_CNT_EN
    chk("arst fetch_count", 32'(a_fc), 32'd0);
    chk("arst stall_count", 32'(a_sc), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    settle();
    chk("post rst a out_pc", 32'(a_pc), 32'd0);
    chk("post rst b out_pc", 32'(b_pc), 32'd3);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
